// File: rtl/fdiv_sched_pkg.sv
// Shared types and constants for the fdiv scheduler: FSM states, op codes
// and the quiet-NaN pattern returned when a divide is abandoned.
package fdiv_sched_pkg;

    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Rounding-mode style op field forwarded untouched to the divider.
    localparam logic [1:0] OP_RNE = 2'd0;
    localparam logic [1:0] OP_RTZ = 2'd1;
    localparam logic [1:0] OP_RDN = 2'd2;
    localparam logic [1:0] OP_RUP = 2'd3;

    // Negative quiet NaN: sign set, exponent all ones, mantissa MSB set.
    function automatic logic [63:0] nan_bits(input int expw, input int manw);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < expw; i++) begin
            v[manw + i] = 1'b1;
        end
        v[manw - 1]    = 1'b1;
        v[expw + manw] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fdiv_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping, and reports the granted index.
module fdiv_sched_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);

    logic          found_s;
    int            idx_s;
    logic [PW-1:0] sel_s;

    // Scan from ptr, wrapping once around the requester ring.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = 0;
        sel_s     = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx_s = int'(ptr) + off;
            if (idx_s >= NREQ) begin
                idx_s = idx_s - NREQ;
            end else begin
                idx_s = idx_s;
            end
            sel_s = PW'(idx_s);
            if (!found_s && req[sel_s]) begin
                found_s      = 1'b1;
                grant[sel_s] = 1'b1;
                grant_idx    = sel_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fdiv_sched.sv
// Round-robin scheduler sharing one iterative fdiv unit among NREQ requesters.
// Optional WAIT watchdog enabled by defining FDIV_SCHED_TIMEOUT_EN.
module fdiv_sched
    import fdiv_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DATAW       = 32,
    parameter int EXPW        = 8,
    parameter int MANW        = 23,
    parameter int DRAIN_CYC   = 2*MANW+3,
    parameter int TIMEOUT_CYC = 2*MANW+8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*DATAW-1:0] req_a,
    input  logic [NREQ*DATAW-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [DATAW-1:0]      rsp_q,
    output logic                  rsp_err,
    output logic                  div_dispatch,
    output logic [DATAW-1:0]      div_a,
    output logic [DATAW-1:0]      div_b,
    output logic [1:0]            div_op,
    input  logic                  div_done,
    input  logic [DATAW-1:0]      div_q,
    output logic                  busy
);

    localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (DRAIN_CYC > TIMEOUT_CYC) ? DRAIN_CYC : TIMEOUT_CYC;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [DATAW-1:0] NAN_Q      = DATAW'(nan_bits(EXPW, MANW));
    localparam logic [CNTW-1:0]  DRAIN_INIT = CNTW'(DRAIN_CYC);
    localparam logic [NREQ-1:0]  ONE_HOT0   = NREQ'(1);

    state_t           state_r, state_nxt;
    logic [PW-1:0]    rr_ptr_r, owner_r, grant_idx_s;
    logic [NREQ-1:0]  grant_s;
    logic [CNTW-1:0]  cnt_r;
    logic             accept_s, timeout_s, finish_s;
    logic [NREQ-1:0]  rsp_valid_r;
    logic [DATAW-1:0] rsp_q_r, div_a_r, div_b_r;
    logic             rsp_err_r, div_dispatch_r;
    logic [1:0]       div_op_r;

    fdiv_sched_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

`ifdef FDIV_SCHED_TIMEOUT_EN
    localparam logic [CNTW-1:0] TIMEOUT_LAST = CNTW'(TIMEOUT_CYC - 1);
    assign timeout_s = (cnt_r == TIMEOUT_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    assign accept_s  = (state_r == ST_IDLE) && (grant_s != '0);
    assign finish_s  = (state_r == ST_WAIT) && (div_done || timeout_s);
    assign req_ready = (state_r == ST_IDLE) ? grant_s : '0;
    assign busy      = (state_r != ST_IDLE);

    assign rsp_valid    = rsp_valid_r;
    assign rsp_q        = rsp_q_r;
    assign rsp_err      = rsp_err_r;
    assign div_dispatch = div_dispatch_r;
    assign div_a        = div_a_r;
    assign div_b        = div_b_r;
    assign div_op       = div_op_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_DRAIN;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state decode; a watchdog response detours through DRAIN so the
    // abandoned divide can finish before the unit is reused.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_DRAIN: state_nxt = (cnt_r == '0) ? ST_IDLE : ST_DRAIN;
            ST_IDLE:  state_nxt = accept_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = finish_s ? ST_RESP : ST_WAIT;
            ST_RESP:  state_nxt = rsp_err_r ? ST_DRAIN : ST_IDLE;
            default:  state_nxt = ST_DRAIN;
        endcase
    end

    // Shared counter: drain countdown, and WAIT cycle count for the watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= DRAIN_INIT;
        end else begin
            case (state_r)
                ST_DRAIN: if (cnt_r != '0) cnt_r <= cnt_r - CNTW'(1);
                ST_ISSUE: cnt_r <= '0;
                ST_WAIT:  cnt_r <= cnt_r + CNTW'(1);
                ST_RESP:  if (rsp_err_r) cnt_r <= DRAIN_INIT;
                default:  cnt_r <= cnt_r;
            endcase
        end
    end

    // Operand capture, dispatch pulse and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r       <= '0;
            owner_r        <= '0;
            div_dispatch_r <= 1'b0;
            div_a_r        <= '0;
            div_b_r        <= '0;
            div_op_r       <= 2'd0;
            rsp_valid_r    <= '0;
            rsp_q_r        <= '0;
            rsp_err_r      <= 1'b0;
        end else begin
            div_dispatch_r <= accept_s;
            rsp_valid_r    <= '0;
            rsp_err_r      <= 1'b0;
            if (accept_s) begin
                div_a_r  <= req_a[int'(grant_idx_s)*DATAW +: DATAW];
                div_b_r  <= req_b[int'(grant_idx_s)*DATAW +: DATAW];
                div_op_r <= req_op[int'(grant_idx_s)*2 +: 2];
                owner_r  <= grant_idx_s;
                rr_ptr_r <= (grant_idx_s == PW'(NREQ-1)) ? '0 : grant_idx_s + PW'(1);
            end
            if (finish_s) begin
                rsp_valid_r <= ONE_HOT0 << owner_r;
                rsp_q_r     <= div_done ? div_q : NAN_Q;
                rsp_err_r   <= ~div_done;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_sched.sv
// Scoreboard bench for fdiv_sched with a behavioural fdiv stub and a
// round-robin / latency reference model.
module tb_fdiv_sched;

    localparam int NREQ        = 4;
    localparam int DATAW       = 32;
    localparam int EXPW        = 8;
    localparam int MANW        = 23;
    localparam int DRAIN_CYC   = 2*MANW+3;
    localparam int TIMEOUT_CYC = 2*MANW+8;
    localparam int SLOW_LAT    = 2*MANW+4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DATAW-1:0] req_a = '0;
    logic [NREQ*DATAW-1:0] req_b = '0;
    logic [NREQ*2-1:0]     req_op = '0;
    logic [NREQ-1:0]       req_ready, rsp_valid;
    logic [DATAW-1:0]      rsp_q, div_a, div_b;
    logic                  rsp_err, div_dispatch, busy;
    logic [1:0]            div_op;
    logic                  div_done = 1'b0;
    logic [DATAW-1:0]      div_q = '0;

    typedef struct {
        int          owner;
        logic [31:0] q;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t            sb[$];
    int              grant_log[$];
    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              model_ptr = 0;
    int              stub_cnt = 0;
    logic [31:0]     stub_val = '0;
    logic            stub_hold = 1'b0;
    logic [NREQ-1:0] last_xfer = '0;

    fdiv_sched #(
        .NREQ(NREQ), .DATAW(DATAW), .EXPW(EXPW), .MANW(MANW),
        .DRAIN_CYC(DRAIN_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err),
        .div_dispatch(div_dispatch), .div_a(div_a), .div_b(div_b), .div_op(div_op),
        .div_done(div_done), .div_q(div_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Divider behaviour: known spec vectors, IEEE special cases, else a scramble.
    function automatic logic [31:0] fdiv_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 32'hFFC00000;
        if (b[30:0] == 31'd0) return {a[31] ^ b[31], 8'hFF, 23'd0};
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h3F000000;
        if (a == 32'h40400000 && b == 32'h3FC00000) return 32'h40000000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    function automatic int fdiv_lat(input logic [31:0] a, input logic [31:0] b);
        if (b[22:0] == 23'd0 || a[30:0] == 31'd0 || a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 1;
        return SLOW_LAT;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // fdiv stub: no reset, ignores dispatch while a divide is in progress.
    always @(posedge clk) begin
        int l;
        div_done <= 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                div_done <= 1'b1;
                div_q    <= stub_val;
            end
        end else if (div_dispatch && !stub_hold) begin
            l = fdiv_lat(div_a, div_b);
            if (l == 1) begin
                div_done <= 1'b1;
                div_q    <= fdiv_fn(div_a, div_b, div_op);
            end else begin
                stub_cnt <= l - 1;
                stub_val <= fdiv_fn(div_a, div_b, div_op);
            end
        end
    end

    // Transfer observer: checks round-robin choice and queues the expected response.
    always @(posedge clk) begin
        int midx, didx;
        logic [31:0] a, b;
        logic [1:0] op;
        exp_t e;
        if (!rst_n) begin
            model_ptr = 0;
            last_xfer = '0;
            sb.delete();
        end else begin
            last_xfer = req_valid & req_ready;
            if (last_xfer != '0) begin
                midx = -1;
                didx = -1;
                for (int off = 0; off < NREQ; off++) begin
                    if (midx < 0 && req_valid[(model_ptr + off) % NREQ]) midx = (model_ptr + off) % NREQ;
                end
                for (int k = 0; k < NREQ; k++) begin
                    if (didx < 0 && last_xfer[k]) didx = k;
                end
                check("grant", last_xfer, onehot(midx));
                grant_log.push_back(didx);
                a  = req_a[midx*DATAW +: DATAW];
                b  = req_b[midx*DATAW +: DATAW];
                op = req_op[midx*2 +: 2];
                e.owner = midx;
                if (stub_hold) begin
                    e.q   = 32'hFFC00000;
                    e.err = 1'b1;
                    e.cyc = cyc + 2 + TIMEOUT_CYC;
                end else begin
                    e.q   = fdiv_fn(a, b, op);
                    e.err = 1'b0;
                    e.cyc = cyc + 2 + fdiv_lat(a, b);
                end
                sb.push_back(e);
                model_ptr = (midx + 1) % NREQ;
            end
        end
        cyc++;
    end

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b q=%h with none outstanding (cycle %0d)", rsp_valid, rsp_q, cyc);
                end else begin
                    e = sb.pop_front();
                    check("rsp_owner", rsp_valid, onehot(e.owner));
                    check("rsp_q", rsp_q, e.q);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                total++;
                bad++;
                $display("FAIL rsp_missing: no rsp for requester %0d, required by cycle %0d", sb[0].owner, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        req_valid = req_valid & ~last_xfer;
    endtask

    task automatic post(input int id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        req_a[id*DATAW +: DATAW] = a;
        req_b[id*DATAW +: DATAW] = b;
        req_op[id*2 +: 2]        = op;
        req_valid[id]            = 1'b1;
    endtask

    task automatic post_rand(input int id);
        logic [31:0] b;
        b = $urandom;
        if ($urandom_range(0, 1) == 0) b[22:0] = 23'd0;
        post(id, $urandom, b, 2'($urandom_range(0, 3)));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || req_valid != '0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: %0d outstanding after %0d cycles", sb.size(), budget);
            sb.delete();
            req_valid = '0;
        end
    endtask

    task automatic check_drain();
        int seen;
        seen = 0;
        #1;
        check("busy_drain", busy, 1);
        if (req_ready != '0) seen++;
        repeat (DRAIN_CYC) begin
            step();
            #1;
            if (req_ready != '0) seen++;
        end
        check("drain_ready_cycles", seen, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_dispatch", div_dispatch, 0);
        rst_n = 1'b1;

        post(0, 32'h3F800000, 32'h40000000, 2'd0);
        check_drain();
        wait_idle(200);
        post(1, 32'h40400000, 32'h3FC00000, 2'd0);
        wait_idle(200);
        post(2, 32'h3F800000, 32'h00000000, 2'd0);
        wait_idle(200);
        post(2, 32'h00000000, 32'h00000000, 2'd0);
        wait_idle(200);
        post(3, 32'h40800000, 32'h40000000, 2'd1);
        wait_idle(200);

        // All requesters held valid: grants must rotate 0,1,2,3,0.
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) post_rand(i);
        n = 0;
        while (grant_log.size() < 5 && n < 2000) begin
            step();
            for (int i = 0; i < NREQ; i++) if (!req_valid[i]) post_rand(i);
            n++;
        end
        for (int k = 0; k < 5; k++) check("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, k % NREQ);
        wait_idle(1000);

        repeat (1500) begin
            step();
            for (int i = 0; i < NREQ; i++) if (!req_valid[i] && $urandom_range(0, 3) == 0) post_rand(i);
        end
        wait_idle(2000);
        repeat (2) step();
        #1;
        check("busy_idle", busy, 0);

        // Reset during WAIT: the in-flight response is dropped.
        post(1, 32'h40400000, 32'h3FC00000, 2'd0);
        n = 0;
        while (sb.size() == 0 && n < 100) begin
            step();
            n++;
        end
        repeat (5) step();
        rst_n = 1'b0;
        sb.delete();
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
        post(0, 32'h40400000, 32'h3FC00000, 2'd2);
        check_drain();
        wait_idle(300);

`ifdef FDIV_SCHED_TIMEOUT_EN
        stub_hold = 1'b1;
        post(2, 32'h3F800000, 32'h40400000, 2'd0);
        wait_idle(300);
        stub_hold = 1'b0;
        post(3, 32'h3F800000, 32'h40000000, 2'd0);
        check_drain();
        wait_idle(300);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
